alu_bit_slice_core: RTL and testbench

ALU_BIT_SLICE_CORE -- requirements
Module: alu_one_bit

---
 rtl/alu_bit_slice_core_pkg.sv | 25 ++
 rtl/alu_bit_slice_core_cell.sv | 27 ++
 rtl/alu_bit_slice_core.sv | 97 +++++++++
 tb/tb_alu_bit_slice_core.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_bit_slice_core_pkg.sv
// Shared constants and types for the 64-bit bit-slice ALU.
package alu_bit_slice_core_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASSB = 3'b000,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RST = '{negative: 1'b0, zero: 1'b1, overflow: 1'b0, carry_out: 1'b0};

endpackage

// File: rtl/alu_bit_slice_core_cell.sv
// One-bit ALU slice: logic ops plus separate add and subtract (A + ~B) full adders.
module alu_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_add_i,
    input  logic cin_sub_i,
    output logic and_o,
    output logic or_o,
    output logic xor_o,
    output logic sum_add_o,
    output logic sum_sub_o,
    output logic cout_add_o,
    output logic cout_sub_o
);

    logic b_inv;

    assign b_inv      = ~b_i;
    assign and_o      = a_i & b_i;
    assign or_o       = a_i | b_i;
    assign xor_o      = a_i ^ b_i;
    assign sum_add_o  = a_i ^ b_i ^ cin_add_i;
    assign cout_add_o = (a_i & b_i) | (cin_add_i & (a_i ^ b_i));
    assign sum_sub_o  = a_i ^ b_inv ^ cin_sub_i;
    assign cout_sub_o = (a_i & b_inv) | (cin_sub_i & (a_i ^ b_inv));

endmodule

// File: rtl/alu_bit_slice_core.sv
// 64-bit ALU built from a chain of one-bit cells; result and flags registered (latency 1).
module alu_bit_slice_core
    import alu_bit_slice_core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   cntrl,
    output logic [DATA_W-1:0] result,
    output logic              negative,
    output logic              zero,
    output logic              overflow,
    output logic              carry_out
);

    logic [DATA_W-1:0] and_c;
    logic [DATA_W-1:0] or_c;
    logic [DATA_W-1:0] xor_c;
    logic [DATA_W-1:0] sum_add_c;
    logic [DATA_W-1:0] sum_sub_c;
    logic [DATA_W-1:0] cout_add_c;
    logic [DATA_W-1:0] cout_sub_c;

    logic [DATA_W-1:0] result_d, result_q;
    alu_flags_t        flags_d, flags_q;

    // Ripple chains: ADD starts with carry 0, SUB with carry 1 (A + ~B + 1).
    for (genvar i = 0; i < DATA_W; i++) begin : g_slice
        logic cin_add;
        logic cin_sub;
        if (i == 0) begin : g_lsb
            assign cin_add = 1'b0;
            assign cin_sub = 1'b1;
        end else begin : g_chain
            assign cin_add = cout_add_c[i-1];
            assign cin_sub = cout_sub_c[i-1];
        end

        alu_bit_cell u_cell (
            .a_i        (A[i]),
            .b_i        (B[i]),
            .cin_add_i  (cin_add),
            .cin_sub_i  (cin_sub),
            .and_o      (and_c[i]),
            .or_o       (or_c[i]),
            .xor_o      (xor_c[i]),
            .sum_add_o  (sum_add_c[i]),
            .sum_sub_o  (sum_sub_c[i]),
            .cout_add_o (cout_add_c[i]),
            .cout_sub_o (cout_sub_c[i])
        );
    end

    // Result select, zero detect and chain-select for carry/overflow.
    always_comb begin
        result_d = '0;
        flags_d  = FLAGS_RST;

        case (alu_op_e'(cntrl))
            OP_PASSB: result_d = B;
            OP_ADD:   result_d = sum_add_c;
            OP_SUB:   result_d = sum_sub_c;
            OP_AND:   result_d = and_c;
            OP_OR:    result_d = or_c;
            OP_XOR:   result_d = xor_c;
            default:  result_d = '0;
        endcase

        flags_d.negative = result_d[DATA_W-1];
        flags_d.zero     = ~(|result_d);
        if (cntrl[0]) begin
            flags_d.carry_out = cout_sub_c[DATA_W-1];
            flags_d.overflow  = cout_sub_c[DATA_W-1] ^ cout_sub_c[DATA_W-2];
        end else begin
            flags_d.carry_out = cout_add_c[DATA_W-1];
            flags_d.overflow  = cout_add_c[DATA_W-1] ^ cout_add_c[DATA_W-2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= FLAGS_RST;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result    = result_q;
    assign negative  = flags_q.negative;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign carry_out = flags_q.carry_out;

endmodule

// File: tb/tb_alu_bit_slice_core.sv
// Scoreboard bench for alu_bit_slice_core: directed vectors with hand-computed results.
module tb_alu_bit_slice_core;

    typedef struct {
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_bit_slice_core dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge.
    task automatic issue(input string name, input logic rst, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] res, input logic n, input logic z,
                         input logic v, input logic c);
        exp_t e;
        @(negedge clk);
        reset = rst;
        cntrl = op;
        A     = a;
        B     = b;
        e.res = res; e.n = n; e.z = z; e.v = v; e.c = c; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: every output edge corresponds to one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (result === e.res && negative === e.n && zero === e.z &&
                    overflow === e.v && carry_out === e.c) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got res=%h n=%b z=%b v=%b c=%b, expected res=%h n=%b z=%b v=%b c=%b",
                             e.name, result, negative, zero, overflow, carry_out,
                             e.res, e.n, e.z, e.v, e.c);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        cntrl = 3'b010;
        A     = 64'h1234;
        B     = 64'h5678;

        // Reset wins over an ADD sampled in the same cycle.
        issue("reset0", 1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1, 0, 0);
        issue("reset1", 1'b1, 3'b011, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0);

        issue("add_ovf",  0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
              64'h8000_0000_0000_0000, 1, 0, 1, 0);
        issue("sub_eq",   0, 3'b011, 64'd5, 64'd5, 64'h0, 0, 1, 0, 1);
        issue("sub_borrow", 0, 3'b011, 64'd0, 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);
        issue("add_wrap", 0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1, 0, 1);
        issue("and",      0, 3'b100, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0);
        issue("or",       0, 3'b101, 64'hF0F0, 64'hFF00, 64'hFFF0, 0, 0, 0, 0);
        issue("xor",      0, 3'b110, 64'hF0F0, 64'hFF00, 64'h0FF0, 0, 0, 0, 0);
        issue("passb",    0, 3'b000, 64'hF0F0, 64'hFF00, 64'hFF00, 0, 0, 0, 0);
        // Unused codes force result 0 but keep SUB-chain flags (cntrl[0]=1).
        issue("op001",    0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1, 0, 1);
        issue("op111",    0, 3'b111, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 0, 1, 1, 1);
        issue("sub_ovf",  0, 3'b011, 64'h8000_0000_0000_0000, 64'h1,
              64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
        issue("add_negovf", 0, 3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h0, 0, 1, 1, 1);
        issue("and_addflags", 0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 0, 0, 0, 1);
        issue("passb_neg", 0, 3'b000, 64'h0, 64'h8000_0000_0000_0001,
              64'h8000_0000_0000_0001, 1, 0, 0, 0);

        // Reset in the middle of back-to-back ADDs.
        issue("add_a",    0, 3'b010, 64'd1, 64'd2, 64'd3, 0, 0, 0, 0);
        issue("add_rst",  1, 3'b010, 64'd3, 64'd4, 64'h0, 0, 1, 0, 0);
        issue("add_b",    0, 3'b010, 64'd5, 64'd6, 64'd11, 0, 0, 0, 0);
        issue("add_c",    0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
              64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
